rr_request_agent: RTL

//  Client-side front end for the 4-way round-robin arbiter. Queues job tokens per

---
 rtl/rr_pkg.sv | 30 +++
 rtl/rr_pend_counter.sv | 33 +++
 rtl/rr_request_agent.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin request agent.
// Holds the FSM state encoding, the default client count, the client index
// width and the grant decode helpers used by the top level.
package rr_pkg;

    localparam int N_CLIENTS_DEF = 4;
    localparam int ID_W          = $clog2(N_CLIENTS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [N_CLIENTS_DEF-1:0] v);
        return (v != '0) && ((v & (v - N_CLIENTS_DEF'(1))) == '0);
    endfunction

    // Index of the set bit of a one-hot vector (OR of set positions).
    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_CLIENTS_DEF-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CLIENTS_DEF; i++) begin
            if (v[i]) idx = idx | ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pend_counter.sv
// Per-client pending job counter.
// Saturates at 2**CNT_W-1 (further pushes are dropped), never underflows.
// An increment and a decrement in the same cycle cancel, even when full.
module rr_pend_counter #(
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonzero
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // Count pending jobs: push adds one unless full, accepted grant removes one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full    = (cnt == CNT_MAX);
    assign nonzero = (cnt != '0);

endmodule

// File: rtl/rr_request_agent.sv
// Client-side front end for a round-robin arbiter.
// Queues job tokens per client, raises requests from registered counter state,
// accepts a one-hot grant and runs one BURST_LEN-beat burst per grant followed
// by a single idle GAP cycle. Illegal grants are ignored and flagged stickily.
// Optional starvation watchdog enabled by defining RR_TIMEOUT_EN.
//
// Handshake: a grant is accepted only in IDLE, only when one-hot and only when
// the granted client has pending work; every other nonzero grant is dropped and
// sets grant_err. xfer_valid/xfer_id/xfer_last carry no back-pressure.
module rr_request_agent
    import rr_pkg::*;
#(
    parameter int N_CLIENTS = N_CLIENTS_DEF,
    parameter int CNT_W     = 3,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CLIENTS-1:0] job_push,
    output logic [N_CLIENTS-1:0] job_full,
    output logic [N_CLIENTS-1:0] request_sig,
    input  logic [N_CLIENTS-1:0] grant,
    output logic                 xfer_valid,
    output logic [ID_W-1:0]      xfer_id,
    output logic                 xfer_last,
    output logic                 grant_err,
    output logic [N_CLIENTS-1:0] timeout_err
);

    localparam int                BEAT_W    = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t               state;
    state_t               state_next;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [ID_W-1:0]      id_q;
    logic [N_CLIENTS-1:0] pend_nz;
    logic [N_CLIENTS-1:0] grant_dec;
    logic                 accept;

    assign accept    = (state == IDLE) && is_onehot(grant) && ((grant & pend_nz) != '0);
    assign grant_dec = accept ? grant : '0;

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_pend
        rr_pend_counter #(.CNT_W(CNT_W)) u_pend (
            .clk     (clk),
            .rst     (rst),
            .inc     (job_push[i]),
            .dec     (grant_dec[i]),
            .full    (job_full[i]),
            .nonzero (pend_nz[i])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: IDLE -> XFER on accepted grant, XFER for BURST_LEN beats, one GAP cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = XFER;
            XFER:    if (beat_cnt == LAST_BEAT) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat counter and latched client index for the running burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            id_q     <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
            id_q     <= onehot_to_idx(grant);
        end else if (state == XFER) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Sticky illegal-grant flag: any nonzero grant that was not accepted.
    always_ff @(posedge clk) begin
        if (rst)                          grant_err <= 1'b0;
        else if ((grant != '0) && !accept) grant_err <= 1'b1;
    end

    assign xfer_valid  = (state == XFER);
    assign xfer_last   = xfer_valid && (beat_cnt == LAST_BEAT);
    assign xfer_id     = xfer_valid ? id_q : '0;
    assign request_sig = (state == IDLE) ? pend_nz : '0;

`ifdef RR_TIMEOUT_EN
    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0]    wait_cnt [N_CLIENTS];
    logic [N_CLIENTS-1:0] to_err;

    // Starvation watch: count requesting cycles per client, flag on reaching TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CLIENTS; i++) wait_cnt[i] <= '0;
            to_err <= '0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (grant_dec[i]) begin
                    wait_cnt[i] <= '0;
                end else if (request_sig[i] && (wait_cnt[i] != WAIT_MAX)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    if (wait_cnt[i] == WAIT_MAX - 1'b1) to_err[i] <= 1'b1;
                end
            end
        end
    end

    assign timeout_err = to_err;
`else
    assign timeout_err = '0;

    // The watchdog is compiled out; a non-positive TIMEOUT would be meaningless anyway.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

endmodule
